rotary_led_stepper: RTL and testbench

//   Downstream consumer of the rotary decoder's rotation_event / rotation_direction pair.

---
 rtl/rotary_pkg.sv | 36 +++
 rtl/rotary_step_detect.sv | 24 ++
 rtl/rotary_led_stepper.sv | 149 ++++++++++++++
 tb/tb_rotary_led_stepper.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary LED stepper: FSM state encoding,
// rotation direction codes, LED bus width and the LED rotate helper.
package rotary_pkg;

    // Width of the board LED bus driven by the stepper.
    localparam int LED_W = 8;

    // Rotation direction codes as delivered by the rotary decoder.
    localparam logic DIR_CW  = 1'b0;  // clockwise: increment position, rotate LEDs left
    localparam logic DIR_CCW = 1'b1;  // counter-clockwise: decrement, rotate LEDs right

    // Step sequencer states. HOLDOFF is only reachable when the
    // post-step lockout feature is compiled in.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STEP    = 2'd1,
        HOLDOFF = 2'd2
    } step_state_e;

    // Rotate the one-hot LED pattern by one position in the given direction.
    // A rotate never creates or destroys set bits, so a one-hot pattern
    // stays one-hot forever.
    function automatic logic [LED_W-1:0] rotate_led(
        input logic [LED_W-1:0] led_in,
        input logic             dir
    );
        logic [LED_W-1:0] led_out;
        if (dir == DIR_CW) begin
            led_out = {led_in[LED_W-2:0], led_in[LED_W-1]};
        end else begin
            led_out = {led_in[0], led_in[LED_W-1:1]};
        end
        return led_out;
    endfunction

endpackage

// File: rtl/rotary_step_detect.sv
// Rising-edge detector for the decoder's rotation_event level.
// The history register resets to 1 so an event line that is already high
// when reset is released is not mistaken for a fresh detent step.
module rotary_step_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic event_i,
    output logic rise_o
);

    logic evt_q;

    // Track the previous event level every cycle, regardless of FSM state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_q <= 1'b1;
        end else begin
            evt_q <= event_i;
        end
    end

    assign rise_o = event_i & ~evt_q;

endmodule

// File: rtl/rotary_led_stepper.sv
// Rotary LED stepper: consumes rotation_event / rotation_direction from the
// rotary decoder. Each accepted rising edge of rotation_event rotates an
// 8-bit one-hot LED pattern and moves a signed position counter one step,
// with a single-cycle step_pulse strobe two clocks after the edge is seen.
//
// Build option: define ROT_STEP_HOLDOFF_EN to add a post-step lockout of
// HOLDOFF_CYCLES cycles during which new rising edges are discarded.
// Without it the sequencer returns straight to IDLE after each step.
module rotary_led_stepper
    import rotary_pkg::*;
#(
    parameter int               POS_W          = 8,
    parameter logic [LED_W-1:0] LED_INIT       = 8'h01,
    parameter bit               SATURATE       = 1'b0,
    parameter int               HOLDOFF_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rotation_event,
    input  logic                    rotation_direction,
    output logic [LED_W-1:0]        led,
    output logic signed [POS_W-1:0] position,
    output logic                    step_pulse,
    output logic                    step_dir
);

`ifdef ROT_STEP_HOLDOFF_EN
    localparam bit HOLDOFF_EN = 1'b1;
`else
    localparam bit HOLDOFF_EN = 1'b0;
`endif

    // Lockout counter sizing; it counts HOLDOFF_CYCLES-1 down to 0.
    localparam int HO_W    = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam int HO_LAST = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;
    localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HO_LAST);

    // Signed position limits and unit step.
    localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    step_state_e      state_q, state_d;
    logic             dir_lat_q, dir_lat_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             step_pulse_q, step_pulse_d;
    logic             step_dir_q, step_dir_d;
    logic [HO_W-1:0]  ho_cnt_q, ho_cnt_d;
    logic [POS_W-1:0] pos_stepped;
    logic             rise;

    rotary_step_detect u_step_detect (
        .clk     (clk),
        .rst_n   (rst_n),
        .event_i (rotation_event),
        .rise_o  (rise)
    );

    // Position after one step in the latched direction, wrapping or clamping.
    always_comb begin
        pos_stepped = pos_q;
        if (dir_lat_q == DIR_CW) begin
            if (!(SATURATE && (pos_q == POS_MAX))) begin
                pos_stepped = pos_q + POS_ONE;
            end
        end else begin
            if (!(SATURATE && (pos_q == POS_MIN))) begin
                pos_stepped = pos_q - POS_ONE;
            end
        end
    end

    // Step sequencer: next state, latched direction, step application and lockout count.
    always_comb begin
        state_d      = state_q;
        dir_lat_d    = dir_lat_q;
        led_d        = led_q;
        pos_d        = pos_q;
        step_pulse_d = 1'b0;
        step_dir_d   = step_dir_q;
        ho_cnt_d     = ho_cnt_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d   = STEP;
                    dir_lat_d = rotation_direction;
                end
            end
            STEP: begin
                led_d        = rotate_led(led_q, dir_lat_q);
                pos_d        = pos_stepped;
                step_pulse_d = 1'b1;
                step_dir_d   = dir_lat_q;
                if (HOLDOFF_EN) begin
                    state_d  = HOLDOFF;
                    ho_cnt_d = HO_LOAD;
                end else begin
                    state_d  = IDLE;
                end
            end
            HOLDOFF: begin
                // Rises arriving here are dropped, not queued.
                if (ho_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    ho_cnt_d = ho_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state register; reset discards any in-flight step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dir_lat_q <= DIR_CW;
            ho_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            dir_lat_q <= dir_lat_d;
            ho_cnt_q  <= ho_cnt_d;
        end
    end

    // Output registers: LED pattern, position, step strobe and last direction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_q        <= LED_INIT;
            pos_q        <= '0;
            step_pulse_q <= 1'b0;
            step_dir_q   <= DIR_CW;
        end else begin
            led_q        <= led_d;
            pos_q        <= pos_d;
            step_pulse_q <= step_pulse_d;
            step_dir_q   <= step_dir_d;
        end
    end

    assign led        = led_q;
    assign position   = pos_q;
    assign step_pulse = step_pulse_q;
    assign step_dir   = step_dir_q;

endmodule

// File: tb/tb_rotary_led_stepper.sv
// Directed bench for rotary_led_stepper. Two instances share clock/reset:
// u_dut (POS_W=8, wrapping) and u_sat (POS_W=4, saturating). Both use
// HOLDOFF_CYCLES=10; expectations that depend on ROT_STEP_HOLDOFF_EN
// follow the same macro.
module tb_rotary_led_stepper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              ev, dir, ev2, dir2;
    logic [7:0]        led, led2;
    logic signed [7:0] pos;
    logic signed [3:0] pos2;
    logic              pulse, sdir, pulse2, sdir2;
    logic [7:0]        pos_u;
    logic [3:0]        pos2_u;

    assign pos_u  = pos;
    assign pos2_u = pos2;

    int checks   = 0;
    int failures = 0;
    int pulse_cnt  = 0;
    int pulse_cnt2 = 0;

    rotary_led_stepper #(
        .POS_W(8), .LED_INIT(8'h01), .SATURATE(1'b0), .HOLDOFF_CYCLES(10)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .rotation_event(ev), .rotation_direction(dir),
        .led(led), .position(pos), .step_pulse(pulse), .step_dir(sdir)
    );

    rotary_led_stepper #(
        .POS_W(4), .LED_INIT(8'h01), .SATURATE(1'b1), .HOLDOFF_CYCLES(10)
    ) u_sat (
        .clk(clk), .rst_n(rst_n),
        .rotation_event(ev2), .rotation_direction(dir2),
        .led(led2), .position(pos2), .step_pulse(pulse2), .step_dir(sdir2)
    );

    // Count strobes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (pulse)  pulse_cnt  = pulse_cnt + 1;
        if (pulse2) pulse_cnt2 = pulse_cnt2 + 1;
    end

    typedef struct {
        logic       dir;
        logic [7:0] led;
        logic [7:0] pos;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One detent step on u_dut, checking latency, strobe width and results.
    task automatic step_main(input logic d, input logic [7:0] eled, input logic [7:0] epos);
        ev = 1'b1; dir = d;
        tick();                          // E0: rise sampled
        check("e0_no_pulse", pulse, 1'b0);
        dir = ~d;                        // direction must already be latched
        tick();                          // E1: step applied
        check("e1_pulse", pulse, 1'b1);
        check("e1_led", led, eled);
        check("e1_pos", pos_u, epos);
        check("e1_dir", sdir, d);
        ev = 1'b0;
        tick();
        check("e2_pulse_low", pulse, 1'b0);
        $display("step dir=%0d led=%02h pos=%0d", d, led, pos);
        repeat (13) tick();
    endtask

    // One detent step on the saturating instance.
    task automatic step_sat(input logic d, input logic [7:0] eled, input logic [3:0] epos);
        ev2 = 1'b1; dir2 = d;
        tick();
        check("sat_e0_no_pulse", pulse2, 1'b0);
        tick();
        check("sat_pulse", pulse2, 1'b1);
        check("sat_led", led2, eled);
        check("sat_pos", pos2_u, epos);
        check("sat_dir", sdir2, d);
        ev2 = 1'b0;
        tick();
        $display("sat step dir=%0d led=%02h pos=%0d", d, led2, pos2);
        repeat (13) tick();
    endtask

    initial begin
        int pm;
        int c0;
        logic [7:0] el;

        vecs[0] = '{1'b1, 8'h80, 8'hFF};   // CCW from reset
        vecs[1] = '{1'b0, 8'h01, 8'h00};
        vecs[2] = '{1'b0, 8'h02, 8'h01};
        vecs[3] = '{1'b0, 8'h04, 8'h02};
        vecs[4] = '{1'b1, 8'h02, 8'h01};

        // Reset
        ev = 1'b0; dir = 1'b0; ev2 = 1'b0; dir2 = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_led", led, 8'h01);
        check("rst_pos", pos_u, 8'h00);
        check("rst_pulse", pulse, 1'b0);
        check("rst_dir", sdir, 1'b0);
        check("rst_sat_led", led2, 8'h01);
        check("rst_sat_pos", pos2_u, 4'h0);
        rst_n = 1'b1;
        repeat (2) tick();
        $display("reset released led=%02h pos=%0d", led, pos);

        // Table of steps from reset
        for (int i = 0; i < 5; i++) begin
            step_main(vecs[i].dir, vecs[i].led, vecs[i].pos);
        end

        // Wrap: climb from 1 to 127, then 127 -> -128 -> 127
        pm = 1;
        for (int k = 0; k < 126; k++) begin
            pm = pm + 1;
            el = 8'h01 << (pm % 8);
            step_main(1'b0, el, 8'(pm));
        end
        step_main(1'b0, 8'h01, 8'h80);
        step_main(1'b1, 8'h80, 8'h7F);

        // Held-high event yields exactly one step
        c0 = pulse_cnt;
        ev = 1'b1; dir = 1'b1;
        repeat (100) tick();
        ev = 1'b0;
        repeat (15) tick();
        check("held_pulses", pulse_cnt - c0, 1);
        check("held_pos", pos_u, 8'h7E);
        check("held_led", led, 8'h40);
        $display("held event led=%02h pos=%0d", led, pos);

        // Reset during an in-flight step, event still high at release
        ev = 1'b1; dir = 1'b0;
        tick();                          // rise sampled, step pending
        rst_n = 1'b0;
        repeat (2) tick();
        check("inflight_led", led, 8'h01);
        check("inflight_pos", pos_u, 8'h00);
        check("inflight_pulse", pulse, 1'b0);
        rst_n = 1'b1;
        c0 = pulse_cnt;
        repeat (20) tick();
        check("rel_high_pulses", pulse_cnt - c0, 0);
        ev = 1'b0;
        repeat (15) tick();
        $display("reset with event high led=%02h pos=%0d", led, pos);

        // Second rise 5 cycles after a pulse, third 12 cycles after
        c0 = pulse_cnt;
        ev = 1'b1; dir = 1'b0;
        tick();                          // E0
        ev = 1'b0;
        tick();                          // E1
        check("ho_first_pulse", pulse, 1'b1);
        repeat (3) tick();               // E2..E4
        ev = 1'b1;
        tick();                          // E5: early rise
        ev = 1'b0;
        tick();                          // E6
`ifdef ROT_STEP_HOLDOFF_EN
        check("ho_early_pulse", pulse, 1'b0);
`else
        check("ho_early_pulse", pulse, 1'b1);
`endif
        repeat (5) tick();               // E7..E11
        ev = 1'b1;
        tick();                          // E12: late rise
        ev = 1'b0;
        tick();                          // E13
        check("ho_late_pulse", pulse, 1'b1);
        repeat (15) tick();
`ifdef ROT_STEP_HOLDOFF_EN
        check("ho_total", pulse_cnt - c0, 2);
`else
        check("ho_total", pulse_cnt - c0, 3);
`endif
        $display("holdoff sequence led=%02h pos=%0d", led, pos);

        // Saturating instance: 9 CW steps then 16 CCW steps
        c0 = pulse_cnt2;
        pm = 0;
        for (int k = 1; k <= 9; k++) begin
            pm = (pm < 7) ? pm + 1 : 7;
            el = 8'h01 << (k % 8);
            step_sat(1'b0, el, 4'(pm));
        end
        check("sat_max_pos", pos2_u, 4'h7);
        check("sat_max_led", led2, 8'h02);
        check("sat_cw_pulses", pulse_cnt2 - c0, 9);
        for (int k = 1; k <= 16; k++) begin
            pm = (pm > -8) ? pm - 1 : -8;
            el = 8'h01 << ((9 - k + 16) % 8);
            step_sat(1'b1, el, 4'(pm));
        end
        check("sat_min_pos", pos2_u, 4'h8);
        check("sat_total_pulses", pulse_cnt2 - c0, 25);
        check("dut_untouched_pulse", pulse, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
